// File: rtl/mod_arbiter.sv
// mod_arbiter: round-robin arbiter that shares one modulo datapath between
// two requesters. A granted operation is latched, issued to the datapath,
// watched for completion or timeout, and answered on the requester's own
// done/res/err outputs.
//
// Ports:
//   CLK, reset              clock and asynchronous active-low reset
//   req0/req1               operation requests, held until doneN
//   a0,b0 / a1,b1           dividend / divisor per requester
//   done0/done1             one-cycle completion pulse per requester
//   res0/res1, err0/err1    remainder and error flag, held until next completion
//   dp_start, dp_a, dp_b    start pulse and latched operands to the datapath
//   dp_done, dp_result      datapath completion and remainder
//   dp_abort                cancels the datapath operation on timeout
//   busy                    high whenever the FSM is not IDLE
module mod_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res0,
  output logic [WIDTH-1:0] res1,
  output logic             err0,
  output logic             err1,
  output logic             dp_start,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic             dp_done,
  input  logic [WIDTH-1:0] dp_result,
  output logic             dp_abort,
  output logic             busy
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  logic [WIDTH-1:0] rslt_q, rslt_d;
  logic             rerr_q, rerr_d;
  logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
  logic             err0_q, err0_d, err1_q, err1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             dp_start_q, dp_start_d;
  logic             dp_abort_q, dp_abort_d;
  logic             busy_q, busy_d;

  // A requester is still holding req in the cycle its done is visible, so it
  // is masked there to avoid serving the same request twice.
  logic req0_ok, req1_ok, pick1;
  assign req0_ok = req0 & ~done0_q;
  assign req1_ok = req1 & ~done1_q;
  // On a tie, serve the requester that was not served last.
  assign pick1   = req1_ok & (~req0_ok | ~last_q);

  // State and output registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      rslt_q     <= '0;
      rerr_q     <= 1'b0;
      res0_q     <= '0;
      res1_q     <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      dp_start_q <= 1'b0;
      dp_abort_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      dp_a_q     <= dp_a_d;
      dp_b_q     <= dp_b_d;
      rslt_q     <= rslt_d;
      rerr_q     <= rerr_d;
      res0_q     <= res0_d;
      res1_q     <= res1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      dp_start_q <= dp_start_d;
      dp_abort_q <= dp_abort_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    dp_a_d     = dp_a_q;
    dp_b_d     = dp_b_q;
    rslt_d     = rslt_q;
    rerr_d     = rerr_q;
    res0_d     = res0_q;
    res1_d     = res1_q;
    err0_d     = err0_q;
    err1_d     = err1_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    dp_start_d = 1'b0;
    dp_abort_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0_ok | req1_ok) begin
          gnt_d  = pick1;
          dp_a_d = pick1 ? a1 : a0;
          dp_b_d = pick1 ? b1 : b0;
          if (dp_b_d == '0) begin
            // Divide-by-zero answers straight away; done is visible in RESP.
            state_d = RESP;
            if (pick1) begin
              done1_d = 1'b1;
              res1_d  = '0;
              err1_d  = 1'b1;
            end else begin
              done0_d = 1'b1;
              res0_d  = '0;
              err0_d  = 1'b1;
            end
          end else begin
            state_d    = ISSUE;
            dp_start_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a timeout in the same cycle.
        if (dp_done) begin
          rslt_d  = dp_result;
          rerr_d  = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rslt_d     = '0;
          rerr_d     = 1'b1;
          dp_abort_d = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        // A zero divisor was already answered on the grant cycle.
        if (dp_b_q != '0) begin
          if (gnt_q) begin
            done1_d = 1'b1;
            res1_d  = rslt_q;
            err1_d  = rerr_q;
          end else begin
            done0_d = 1'b1;
            res0_d  = rslt_q;
            err0_d  = rerr_q;
          end
        end
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign res0     = res0_q;
  assign res1     = res1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign dp_start = dp_start_q;
  assign dp_a     = dp_a_q;
  assign dp_b     = dp_b_q;
  assign dp_abort = dp_abort_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mod_arbiter.sv
// tb_mod_arbiter: directed and random checks of mod_arbiter against a
// transaction-level model (service order, per-op cycle cost, a % b).
// The bench also plays the modulo datapath with a programmable latency.
module tb_mod_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 8;

  logic         CLK = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         done0, done1, err0, err1, dp_start, dp_abort, busy;
  logic [W-1:0] res0, res1, dp_a, dp_b;
  logic         dp_done;
  logic         dp_done_m = 1'b0;
  logic         dp_stray = 1'b0;
  logic [W-1:0] dp_result = '0;

  assign dp_done = dp_done_m | dp_stray;

  mod_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1),
    .res0(res0), .res1(res1),
    .err0(err0), .err1(err1),
    .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b),
    .dp_done(dp_done), .dp_result(dp_result),
    .dp_abort(dp_abort), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           id;
    int           cyc;
    logic [W-1:0] res;
    logic         err;
  } ev_t;

  ev_t          evq[$];
  int           lat_q[$];
  int           cyc = 0;
  int           n_start = 0, n_abort = 0, abort_cyc = -1, n_both = 0;
  bit           pend = 1'b0;
  int           wcnt = 0, cur_lat = 0;
  logic [W-1:0] cap_a = '0, cap_b = '0;

  // Monitor plus datapath stand-in: records completions and answers
  // dp_start after cur_lat WAIT cycles (0 means never answer).
  always @(posedge CLK) begin
    #1;
    cyc++;
    dp_done_m = 1'b0;
    if (done0 && done1) n_both++;
    if (done0) evq.push_back('{0, cyc, res0, err0});
    if (done1) evq.push_back('{1, cyc, res1, err1});
    if (dp_abort) begin
      n_abort++;
      abort_cyc = cyc;
      pend = 1'b0;
    end
    if (!reset) pend = 1'b0;
    if (dp_start) begin
      n_start++;
      pend  = 1'b1;
      wcnt  = 0;
      cap_a = dp_a;
      cap_b = dp_b;
      cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
    end else if (pend) begin
      wcnt++;
      if (cur_lat != 0 && wcnt == cur_lat) begin
        dp_done_m = 1'b1;
        dp_result = (cap_b == '0) ? '0 : cap_a % cap_b;
        pend = 1'b0;
      end
    end
  end

  int n_chk = 0, n_fail = 0;
  int last = 1;   // model: requester served last

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raise the enabled requests together from an idle arbiter, predict the
  // service order and completion cycles, then compare what happened.
  task automatic batch(input string tag, input bit en0, input bit en1,
                       input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                       input logic [W-1:0] xa1, input logic [W-1:0] xb1,
                       input int l0, input int l1, input bit scr);
    int           order[2];
    int           exp_cyc[2];
    logic [W-1:0] exp_res[2];
    logic         exp_err[2];
    int           nops, k, g, ns, na, s0, ab0, lat, n, exp_ab, id, bound;
    logic [W-1:0] a, b;
    for (int c = 0; c < 40 && busy; c++) @(negedge CLK);
    evq.delete();
    lat_q.delete();
    nops = 0;
    if (en0 && en1) begin
      order[0] = (last == 0) ? 1 : 0;
      order[1] = 1 - order[0];
      nops = 2;
    end else if (en0) begin
      order[0] = 0;
      nops = 1;
    end else if (en1) begin
      order[0] = 1;
      nops = 1;
    end
    @(negedge CLK);
    k = cyc;
    g = k; ns = 0; na = 0; exp_ab = -1;
    for (int i = 0; i < nops; i++) begin
      id  = order[i];
      a   = id ? xa1 : xa0;
      b   = id ? xb1 : xb0;
      lat = id ? l1 : l0;
      if (b == '0) begin
        exp_cyc[i] = g + 1;
        exp_res[i] = '0;
        exp_err[i] = 1'b1;
        g = g + 2;
      end else begin
        ns++;
        lat_q.push_back(lat);
        if (lat == 0) begin
          n = TO;
          na++;
          exp_res[i] = '0;
          exp_err[i] = 1'b1;
        end else begin
          n = lat;
          exp_res[i] = a % b;
          exp_err[i] = 1'b0;
        end
        exp_cyc[i] = g + n + 3;
        if (lat == 0) exp_ab = exp_cyc[i] - 1;
        g = g + n + 3;
      end
      last = id;
    end
    s0  = n_start;
    ab0 = n_abort;
    a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    req0 = en0; req1 = en1;
    if (scr) begin
      @(negedge CLK);
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    end
    bound = g - k + 8;
    for (int c = 0; c < bound && evq.size() < nops; c++) begin
      @(negedge CLK);
      if (done0) req0 = 1'b0;
      if (done1) req1 = 1'b0;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge CLK);
    chk({tag, "_nevents"}, W'(evq.size()), W'(nops));
    for (int i = 0; i < nops && i < evq.size(); i++) begin
      chk({tag, "_id"},  W'(evq[i].id),  W'(order[i]));
      chk({tag, "_cyc"}, W'(evq[i].cyc - k), W'(exp_cyc[i] - k));
      chk({tag, "_res"}, evq[i].res, exp_res[i]);
      chk({tag, "_err"}, W'(evq[i].err), W'(exp_err[i]));
    end
    chk({tag, "_starts"}, W'(n_start - s0), W'(ns));
    chk({tag, "_aborts"}, W'(n_abort - ab0), W'(na));
    if (na > 0) chk({tag, "_abort_cyc"}, W'(abort_cyc - k), W'(exp_ab - k));
    chk({tag, "_busy"}, W'(busy), W'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flags"}, W'({done0, done1, err0, err1, dp_start, dp_abort, busy}), W'(0));
    chk({tag, "_res0"}, res0, '0);
    chk({tag, "_res1"}, res1, '0);
    chk({tag, "_dp_a"}, dp_a, '0);
    chk({tag, "_dp_b"}, dp_b, '0);
  endtask

  initial begin
    int           e0, e1, l0, l1, sel, ev0;
    logic [W-1:0] ra0, rb0, ra1, rb1;

    // Reset state.
    repeat (2) @(negedge CLK);
    chk_reset_outputs("reset");
    reset = 1'b1;
    @(negedge CLK);

    // Tie straight out of reset: requester 0 first, then 1.
    batch("tie", 1'b1, 1'b1, 32'd9, 32'd4, 32'd10, 32'd3, 3, 2, 1'b0);
    // Single op with operand scramble after grant.
    batch("basic", 1'b1, 1'b0, 32'd17, 32'd5, 32'd0, 32'd0, 4, 0, 1'b1);
    chk("basic_dp_a", cap_a, 32'd17);
    chk("basic_dp_b", cap_b, 32'd5);
    batch("div0", 1'b0, 1'b1, 32'd0, 32'd0, 32'd8, 32'd0, 0, 0, 1'b0);
    batch("timeout", 1'b1, 1'b0, 32'd23, 32'd7, 32'd0, 32'd0, 0, 0, 1'b0);
    batch("coincide", 1'b0, 1'b1, 32'd0, 32'd0, 32'd11, 32'd4, 0, TO, 1'b0);
    batch("tie_dz", 1'b1, 1'b1, 32'd5, 32'd0, 32'd7, 32'd2, 0, 1, 1'b0);

    // Reset during WAIT, then a stray dp_done while reset is low.
    evq.delete();
    lat_q.delete();
    lat_q.push_back(0);
    @(negedge CLK);
    a0 = 32'd40; b0 = 32'd6; req0 = 1'b1;
    repeat (4) @(negedge CLK);
    ev0 = n_abort;
    reset = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge CLK);
    dp_stray = 1'b1;
    req0 = 1'b0;
    @(negedge CLK);
    dp_stray = 1'b0;
    chk_reset_outputs("midreset_stray");
    chk("midreset_events", W'(evq.size()), W'(0));
    chk("midreset_aborts", W'(n_abort - ev0), W'(0));
    reset = 1'b1;
    last = 1;
    // Stray dp_done while IDLE.
    @(negedge CLK);
    dp_stray = 1'b1;
    @(negedge CLK);
    dp_stray = 1'b0;
    repeat (2) @(negedge CLK);
    chk("stray_idle_busy", W'(busy), W'(0));
    chk("stray_idle_events", W'(evq.size()), W'(0));

    // Random requests, operands and datapath latencies.
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(1, 3);
      e0 = sel & 1;
      e1 = (sel >> 1) & 1;
      ra0 = $urandom; ra1 = $urandom;
      rb0 = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 5000));
      rb1 = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      if (rb1 == '0 && $urandom_range(0, 1) == 1) rb1 = 32'd13;
      l0 = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
      l1 = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
      batch("rand", e0[0], e1[0], ra0, rb0, ra1, rb1, l0, l1, 1'b0);
    end

    chk("never_both_done", W'(n_both), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
